sysbus_mem_responder: RTL
=========================

Name: sysbus_mem_responder

Overview:
- Memory-side responder on the Sysbus: the far end of the fetch initiator in the core top level.
- Accepts cache-line read and write requests on the request channel and returns read data as 8 × 64-bit beats on the response channel.
- Contains a backing array plus a bench/loader backdoor port.
- Used as the simulation memory model and as the reference target for initiator verification.

Parameters:
- BUS_DATA_WIDTH, 64, request/response data width.
- BUS_TAG_WIDTH, 13, tag width; [12] target, [11:8] command, [7:0] transaction id.
- MEM_WORDS, 4096, backing array depth in 64-bit words; power of two.
- LINE_BEATS, 8, beats per line (64 bytes).
- LATENCY, 4, cycles from reqack to first respcyc; minimum 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- bus_reqcyc  in  1  request valid.
- bus_req  in  BUS_DATA_WIDTH  address (header) or write-data beat.
- bus_reqtag  in  BUS_TAG_WIDTH  request tag.
- bus_reqack  out  1  request/beat accepted.
- bus_respcyc  out  1  response beat valid.
- bus_resp  out  BUS_DATA_WIDTH  response data.
- bus_resptag  out  BUS_TAG_WIDTH  echo of captured request tag.
- bus_respack  in  1  initiator accepts current beat.
- ld_en  in  1  backdoor write enable.
- ld_addr  in  $clog2(MEM_WORDS)  backdoor word index.
- ld_data  in  BUS_DATA_WIDTH  backdoor data.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0.
  - Beat counter and latency counter cleared.
  - Array contents retained.
  - Reset mid-transaction abandons the transaction with no further beats.
- Line base index: (bus_req >> 3) with the low 3 bits cleared, taken modulo MEM_WORDS (address wraps silently). Beat i uses index base+i, no critical-word-first.
- Target filter: requests whose tag[12] is not `SYSBUS_MEMORY are never acked; the responder stays in IDLE.
- Commands: tag[11:8] == `SYSBUS_READ selects a read, == `SYSBUS_WRITE selects a write. Any other command is acked and dropped (IDLE → ACK → IDLE).
- IDLE:
  - At a posedge with bus_reqcyc=1 and a memory target, capture the address, tag and command.
  - Next cycle: bus_reqack=1 for exactly one cycle (state ACK).
- ACK:
  - Read → WAIT, with the latency counter loaded to LATENCY-1.
  - Write → WDATA.
- WAIT:
  - Counter decrements each cycle.
  - At 0, load bus_resp=mem[base], set bus_resptag=captured tag and beat=0, assert bus_respcyc → RESP.
  - bus_respcyc first becomes high LATENCY cycles after the bus_reqack cycle.
- RESP:
  - bus_respcyc held high; bus_resp/bus_resptag stable until the beat is accepted.
  - Beat accepted at a posedge where bus_respack=1.
  - On acceptance: beat++ and bus_resp=mem[base+beat+1] from the next cycle.
  - bus_respack=0 stalls indefinitely.
  - After beat LINE_BEATS-1 is accepted, bus_respcyc=0 the next cycle → IDLE.
  - A new request is sampled no earlier than the first IDLE cycle.
- WDATA:
  - bus_reqack = bus_reqcyc (combinational).
  - At each posedge with bus_reqcyc=1, write bus_req to mem[base+beat] and increment beat.
  - After LINE_BEATS beats → IDLE.
  - No response phase for writes.
- Backdoor:
  - ld_en writes mem[ld_addr] at the posedge in any state, including during reset.
  - On a same-cycle same-index collision with a bus write, the backdoor wins.
  - bus_resp is registered, so a backdoor write to the beat currently presented is not visible until that beat is reloaded.
- bus_reqcyc while the responder is busy (WAIT/RESP) is ignored; no ack is given.
- bus_respack outside RESP is ignored.

Test Plan:
- Read, no stall:
  - Stimulus: preload mem[8..15]=0x1000+i; reqcyc with req=0x40, READ|MEMORY tag id 0x05; respack held high.
  - Required: reqack one cycle, first respcyc 4 cycles later, beats 0x1000..0x1007 on consecutive cycles, resptag[7:0]=0x05, then respcyc low and IDLE.
- Stalled read:
  - Stimulus: as above, respack toggled 1,0,0,1,…
  - Required: each beat held stable while respack=0; exactly 8 beats delivered in order.
- Write then read-back:
  - Stimulus: WRITE to 0x80 with data 0xA0..0xA7 (reqcyc continuous), then READ 0x80.
  - Required: 8 reqack cycles during data; readback returns 0xA0..0xA7.
- Alignment and wrap:
  - Stimulus: READ 0x47 (base 8); READ to byte address MEM_WORDS*8+0x40.
  - Required: both return mem[8..15].
- Filter and reset:
  - Stimulus: request with tag[12]=0 → never acked. Assert reset during beat 3 of a read.
  - Required: outputs zero the next cycle; a subsequent read completes normally and preloaded data is intact.

Source files
------------

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory-side responder: cache-line reads and writes over a
// backing array, with a backdoor loader port for benches.
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 1'b1
`endif
`ifndef SYSBUS_READ
`define SYSBUS_READ 4'h1
`endif
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 4'h2
`endif

module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int LINE_BEATS     = 8,
    parameter int LATENCY        = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0]    bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]     bus_reqtag,
    output logic                         bus_reqack,
    output logic                         bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0]    bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]     bus_resptag,
    input  logic                         bus_respack,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
    input  logic [BUS_DATA_WIDTH-1:0]    ld_data
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = $clog2(LINE_BEATS);
    localparam int LW = $clog2(LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_WAIT,
        S_RESP,
        S_WDATA
    } state_t;

    state_t state, state_next;

    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [AW-1:0]            base_q;
    logic [BUS_TAG_WIDTH-1:0] tag_q;
    logic [BW-1:0]            beat_q;
    logic [LW-1:0]            lat_q;

    logic          req_hit;
    logic [AW-1:0] req_base;
    logic          cmd_read;
    logic          cmd_write;
    logic          last_beat;
    logic [BW-1:0] beat_inc;
    logic          load_first;
    logic          resp_adv;
    logic          wr_en;
    logic          unused_req_bits;

    // Byte address -> 64-bit word index, aligned down to a line and wrapped.
    assign req_base  = {bus_req[AW+2:BW+3], {BW{1'b0}}};
    assign req_hit   = bus_reqcyc && (bus_reqtag[12] == `SYSBUS_MEMORY);
    assign cmd_read  = (tag_q[11:8] == `SYSBUS_READ);
    assign cmd_write = (tag_q[11:8] == `SYSBUS_WRITE);
    assign last_beat = (beat_q == BW'(LINE_BEATS - 1));
    assign beat_inc  = beat_q + BW'(1);

    assign resp_adv = (state == S_RESP) && bus_respack && !last_beat;
    assign wr_en    = (state == S_WDATA) && bus_reqcyc && !reset;

    assign bus_respcyc = (state == S_RESP);

    assign unused_req_bits = ^{bus_req[BUS_DATA_WIDTH-1:AW+3],
                               bus_req[BW+2:0]};

    always_comb begin
        state_next = state;
        bus_reqack = 1'b0;
        load_first = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req_hit) begin
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                bus_reqack = 1'b1;
                if (cmd_read) begin
                    if (LATENCY == 1) begin
                        load_first = 1'b1;
                        state_next = S_RESP;
                    end else begin
                        state_next = S_WAIT;
                    end
                end else if (cmd_write) begin
                    state_next = S_WDATA;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (lat_q == LW'(1)) begin
                    load_first = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (bus_respack && last_beat) begin
                    state_next = S_IDLE;
                end
            end
            S_WDATA: begin
                bus_reqack = bus_reqcyc;
                if (bus_reqcyc && last_beat) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            base_q      <= '0;
            tag_q       <= '0;
            beat_q      <= '0;
            lat_q       <= '0;
            bus_resp    <= '0;
            bus_resptag <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && req_hit) begin
                base_q <= req_base;
                tag_q  <= bus_reqtag;
            end
            if (state == S_ACK) begin
                lat_q  <= LW'(LATENCY - 1);
                beat_q <= '0;
            end
            if (state == S_WAIT) begin
                lat_q <= lat_q - LW'(1);
            end
            if (load_first) begin
                bus_resp    <= mem[base_q];
                bus_resptag <= tag_q;
                beat_q      <= '0;
            end
            if (resp_adv) begin
                beat_q   <= beat_inc;
                bus_resp <= mem[base_q + AW'(beat_inc)];
            end
            if (wr_en) begin
                beat_q <= beat_inc;
            end
        end
    end

    // Backdoor is issued last so it wins a same-index collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[base_q + AW'(beat_q)] <= bus_req;
        end
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

endmodule
